// File: rtl/cla_seq_add_ctrl_if.sv
// Bundle of request, shared-adder and result signals for cla_seq_add_ctrl.
// The slave modport is the controller's view. The master modport is the view
// of the environment, which is the requester, the CLA adder and the consumer.
interface cla_seq_add_ctrl_if #(
  parameter int W      = 16,
  parameter int CHUNKS = 4
);
  logic                  in_valid;
  logic                  in_ready;
  logic [W*CHUNKS-1:0]   op_a;
  logic [W*CHUNKS-1:0]   op_b;
  logic                  sub;
  logic [W-1:0]          adder_a;
  logic [W-1:0]          adder_b;
  logic                  adder_cin;
  logic [W-1:0]          adder_sum;
  logic                  adder_cout;
  logic                  out_valid;
  logic                  out_ready;
  logic [W*CHUNKS-1:0]   result;
  logic                  cout;
  logic                  ovf;

  modport slave (
    input  in_valid, op_a, op_b, sub, adder_sum, adder_cout, out_ready,
    output in_ready, adder_a, adder_b, adder_cin, out_valid, result, cout, ovf
  );

  modport master (
    output in_valid, op_a, op_b, sub, adder_sum, adder_cout, out_ready,
    input  in_ready, adder_a, adder_b, adder_cin, out_valid, result, cout, ovf
  );
endinterface

// File: rtl/cla_seq_add_ctrl.sv
// Sequencing controller for a wide add or subtract on one shared W-bit CLA adder.
// It handles one chunk per cycle, starting with the LSB chunk, and chains the
// carry through carry_reg. For subtraction, B is inverted when it is loaded and
// the initial carry is set to 1, so the adder always computes A + B' + cin.
module cla_seq_add_ctrl #(
  parameter int W      = 16,
  parameter int CHUNKS = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  cla_seq_add_ctrl_if.slave    bus
);
  localparam int TW  = W * CHUNKS;
  localparam int MSB = TW - 1;
  localparam int IW  = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state;
  state_t          state_next;
  logic [IW-1:0]   idx;
  logic            carry_reg;
  logic [TW-1:0]   a_reg;
  logic [TW-1:0]   b_reg;
  logic [TW-1:0]   result_reg;
  logic            cout_reg;
  logic            ovf_reg;
  logic            out_valid_reg;
  logic            last_chunk;
  logic            accept;

  assign last_chunk    = (idx == IW'(CHUNKS - 1));
  assign accept        = bus.in_valid && (state == IDLE);
  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = out_valid_reg;
  assign bus.result    = result_reg;
  assign bus.cout      = cout_reg;
  assign bus.ovf       = ovf_reg;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state logic. The adder pins are driven only in RUN and are held at 0 otherwise.
  always_comb begin
    state_next    = state;
    bus.adder_a   = '0;
    bus.adder_b   = '0;
    bus.adder_cin = 1'b0;
    case (state)
      IDLE: if (bus.in_valid) state_next = RUN;
      RUN: begin
        bus.adder_a   = a_reg[idx*W +: W];
        bus.adder_b   = b_reg[idx*W +: W];
        bus.adder_cin = carry_reg;
        if (last_chunk) state_next = DONE;
      end
      DONE: if (bus.out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Datapath: latch operands, collect chunk sums and the carry chain, and hold the result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx           <= '0;
      carry_reg     <= 1'b0;
      a_reg         <= '0;
      b_reg         <= '0;
      result_reg    <= '0;
      cout_reg      <= 1'b0;
      ovf_reg       <= 1'b0;
      out_valid_reg <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            a_reg     <= bus.op_a;
            b_reg     <= bus.sub ? ~bus.op_b : bus.op_b;
            carry_reg <= bus.sub;
            idx       <= '0;
          end
        end
        RUN: begin
          result_reg[idx*W +: W] <= bus.adder_sum;
          carry_reg              <= bus.adder_cout;
          idx                    <= idx + 1'b1;
          if (last_chunk) begin
            cout_reg      <= bus.adder_cout;
            ovf_reg       <= (a_reg[MSB] == b_reg[MSB]) && (bus.adder_sum[W-1] != a_reg[MSB]);
            out_valid_reg <= 1'b1;
          end
        end
        DONE: begin
          if (bus.out_ready) out_valid_reg <= 1'b0;
        end
        default: out_valid_reg <= 1'b0;
      endcase
    end
  end
endmodule

// File: tb/tb_cla_seq_add_ctrl.sv
// Self-checking bench for cla_seq_add_ctrl.
// It models the CLA adder as a combinational add. Each accepted request pushes
// its expected result onto a scoreboard queue, and each consumed result pops the
// queue and compares.
module tb_cla_seq_add_ctrl;
  localparam int W      = 16;
  localparam int CHUNKS = 4;
  localparam int TW     = W * CHUNKS;

  logic clk = 1'b0;
  logic rst_n;
  int   tests_run = 0;
  int   tests_failed = 0;
  int   cyc = 0;
  int   results_seen = 0;
  logic prev_ov = 1'b0;

  logic [TW+1:0] sb_q[$];
  int            lat_q[$];
  int            acc_log[$];

  cla_seq_add_ctrl_if #(.W(W), .CHUNKS(CHUNKS)) bus();

  cla_seq_add_ctrl #(.W(W), .CHUNKS(CHUNKS)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Behavioural stand-in for the shared CLA adder
  assign {bus.adder_cout, bus.adder_sum} = {1'b0, bus.adder_a} + {1'b0, bus.adder_b}
                                         + {{W{1'b0}}, bus.adder_cin};

  // Clock generation
  always #5 clk = ~clk;

  // Edge counter used for latency and issue-interval checks
  always @(posedge clk) cyc <= cyc + 1;

  // Reference model of the full-width operation: {result, cout, ovf}
  function automatic logic [TW+1:0] model(input logic [TW-1:0] a, input logic [TW-1:0] b,
                                          input logic s);
    logic [TW-1:0] bb;
    logic [TW:0]   sum;
    logic          ov;
    bb  = s ? ~b : b;
    sum = {1'b0, a} + {1'b0, bb} + {{TW{1'b0}}, s};
    ov  = (a[TW-1] == bb[TW-1]) && (sum[TW-1] != a[TW-1]);
    return {sum[TW-1:0], sum[TW], ov};
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive a request and hold it until it is accepted. Returns in RUN cycle 0.
  task automatic applyStimulus(input logic [TW-1:0] a, input logic [TW-1:0] b, input logic s);
    bit done;
    done = 1'b0;
    bus.in_valid = 1'b1;
    bus.op_a     = a;
    bus.op_b     = b;
    bus.sub      = s;
    for (int i = 0; i < 50 && !done; i++) begin
      if (bus.in_ready) done = 1'b1;
      tick();
    end
    bus.in_valid = 1'b0;
    if (!done) checkOutput("accept_timeout", 64'd0, 64'd1);
  endtask

  task automatic waitResults(input int target);
    for (int i = 0; i < 100 && results_seen < target; i++) tick();
    if (results_seen < target) checkOutput("result_timeout", 64'(results_seen), 64'(target));
  endtask

  // Monitor and scoreboard: sample the handshakes on the falling edge
  always @(negedge clk) begin
    logic [TW+1:0] exp;
    if (rst_n) begin
      if (bus.in_valid && bus.in_ready) begin
        sb_q.push_back(model(bus.op_a, bus.op_b, bus.sub));
        lat_q.push_back(cyc + 1);
        acc_log.push_back(cyc + 1);
      end
      if (bus.out_valid && !prev_ov) begin
        if (lat_q.size() > 0) checkOutput("latency", 64'(cyc - lat_q.pop_front()), 64'(CHUNKS));
        else checkOutput("unexpected_valid", 64'd1, 64'd0);
      end
      if (bus.out_valid && bus.out_ready) begin
        if (sb_q.size() == 0) checkOutput("sb_empty", 64'd1, 64'd0);
        else begin
          exp = sb_q.pop_front();
          checkOutput("result", bus.result, exp[TW+1:2]);
          checkOutput("cout", 64'(bus.cout), 64'(exp[1]));
          checkOutput("ovf", 64'(bus.ovf), 64'(exp[0]));
          results_seen++;
        end
      end
      prev_ov = bus.out_valid;
    end else begin
      prev_ov = 1'b0;
    end
  end

  // Test sequence
  initial begin
    logic [3:0] cin_exp;
    int         n;
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.op_a      = '0;
    bus.op_b      = '0;
    bus.sub       = 1'b0;
    bus.out_ready = 1'b1;

    #12;
    checkOutput("rst_out_valid", 64'(bus.out_valid), 64'd0);
    checkOutput("rst_result", bus.result, 64'd0);
    checkOutput("rst_adder_a", 64'(bus.adder_a), 64'd0);
    checkOutput("rst_adder_cin", 64'(bus.adder_cin), 64'd0);
    checkOutput("rst_in_ready", 64'(bus.in_ready), 64'd1);
    #10 rst_n = 1'b1;
    tick();
    checkOutput("idle_in_ready", 64'(bus.in_ready), 64'd1);

    // Carry propagates through every chunk
    cin_exp = 4'b1110;
    applyStimulus(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0);
    for (int i = 0; i < CHUNKS; i++) begin
      checkOutput($sformatf("cin_run%0d", i), 64'(bus.adder_cin), 64'(cin_exp[i]));
      tick();
    end
    waitResults(1);

    // Subtract that borrows
    applyStimulus(64'd5, 64'd7, 1'b1);
    checkOutput("sub_adder_b0", 64'(bus.adder_b), 64'hFFF8);
    checkOutput("sub_adder_a0", 64'(bus.adder_a), 64'd5);
    checkOutput("sub_cin0", 64'(bus.adder_cin), 64'd1);
    waitResults(2);

    // Signed overflow cases
    applyStimulus(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0);
    waitResults(3);
    applyStimulus(64'h8000_0000_0000_0000, 64'd1, 1'b1);
    waitResults(4);

    // Backpressure in DONE while a new request waits
    bus.out_ready = 1'b0;
    applyStimulus(64'd100, 64'd23, 1'b0);
    bus.in_valid = 1'b1;
    bus.op_a     = 64'h1234;
    bus.op_b     = 64'h1111;
    bus.sub      = 1'b0;
    for (int i = 0; i < 20 && !bus.out_valid; i++) tick();
    for (int i = 0; i < 5; i++) begin
      checkOutput("bp_result", bus.result, 64'd123);
      checkOutput("bp_in_ready", 64'(bus.in_ready), 64'd0);
      checkOutput("bp_out_valid", 64'(bus.out_valid), 64'd1);
      tick();
    end
    bus.out_ready = 1'b1;
    tick();
    checkOutput("bp_idle_in_ready", 64'(bus.in_ready), 64'd1);
    tick();
    checkOutput("bp_pending_taken", 64'(bus.in_ready), 64'd0);
    bus.in_valid = 1'b0;
    waitResults(6);

    // Reset while idx == 2
    applyStimulus(64'h0000_FFFF_FFFF_FFFF, 64'd1, 1'b0);
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    checkOutput("mid_rst_in_ready", 64'(bus.in_ready), 64'd1);
    checkOutput("mid_rst_out_valid", 64'(bus.out_valid), 64'd0);
    checkOutput("mid_rst_result", bus.result, 64'd0);
    sb_q.delete();
    lat_q.delete();
    tick();
    rst_n = 1'b1;
    applyStimulus(64'h0000_FFFF_FFFF_FFFF, 64'd1, 1'b0);
    waitResults(7);
    checkOutput("rerun_result", bus.result, 64'h0001_0000_0000_0000);

    // Back-to-back requests with the consumer always ready
    n = acc_log.size();
    bus.in_valid = 1'b1;
    bus.op_a     = 64'd3;
    bus.op_b     = 64'd4;
    bus.sub      = 1'b0;
    for (int i = 0; i < 20 && !bus.in_ready; i++) tick();
    tick();
    bus.op_a = 64'd10;
    bus.op_b = 64'd3;
    bus.sub  = 1'b1;
    for (int i = 0; i < 20 && !bus.in_ready; i++) tick();
    tick();
    bus.in_valid = 1'b0;
    waitResults(9);
    if (acc_log.size() >= n + 2)
      checkOutput("issue_interval", 64'(acc_log[n+1] - acc_log[n]), 64'(CHUNKS + 2));
    else
      checkOutput("issue_count", 64'(acc_log.size() - n), 64'd2);
    checkOutput("b2b_last_result", bus.result, 64'd7);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end
endmodule

// File: doc/cla_seq_add_ctrl.md
Name: cla_seq_add_ctrl

Overview:
- Sequencing controller that performs a wide (W*CHUNKS-bit) add or subtract on one shared, purely combinational W-bit CLA adder.
- Processes one W-bit chunk per cycle, LSB chunk first, and chains the carry through a register.
- Sits between a requester (valid/ready on the input side) and a consumer (valid/ready on the output side).
- Drives the adder's operand and carry-in pins and captures its sum and carry-out.

Parameters:
W, 16, chunk width; must equal the width of the attached CLA adder.
CHUNKS, 4, number of chunks; total operand width is W*CHUNKS; must be >= 2.

Ports:
clk  in  1  system clock, rising edge.
rst_n  in  1  asynchronous, active-low reset.
in_valid  in  1  request carries valid operands.
in_ready  out  1  controller can accept a request; equals (state==IDLE).
op_a  in  W*CHUNKS  operand A.
op_b  in  W*CHUNKS  operand B.
sub  in  1  1 = compute A-B, 0 = compute A+B.
adder_a  out  W  chunk of A presented to the shared adder.
adder_b  out  W  chunk of effective B (inverted when sub) presented to the adder.
adder_cin  out  1  carry-in presented to the adder.
adder_sum  in  W  sum returned by the adder, same cycle.
adder_cout  in  1  carry-out returned by the adder, same cycle.
out_valid  out  1  result, cout and ovf are valid.
out_ready  in  1  consumer accepts the result.
result  out  W*CHUNKS  sum or difference.
cout  out  1  final carry-out; for sub, 1 means no borrow.
ovf  out  1  two's-complement signed overflow.

Behaviour:
- Clock and reset: single clock clk; reset is asynchronous and active-low (rst_n).
- Reset state: state=IDLE, chunk index idx=0, carry_reg=0, a_reg=0, b_reg=0, result=0, cout=0, ovf=0, out_valid=0.
  - The adder_* outputs are 0 while in reset.
  - in_ready is 1 as soon as reset releases.
- States: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1; adder_a, adder_b and adder_cin are driven to 0.
  - A handshake occurs on in_valid & in_ready. On that edge: a_reg<=op_a; b_reg<=sub ? ~op_b : op_b; carry_reg<=sub; idx<=0; next state RUN.
  - The previous result stays on the result port until the first chunk is written.
- RUN:
  - in_ready=0.
  - adder_a = a_reg[idx*W +: W]; adder_b = b_reg[idx*W +: W]; adder_cin = carry_reg.
  - Every cycle: result[idx*W +: W]<=adder_sum; carry_reg<=adder_cout; idx<=idx+1.
  - When idx==CHUNKS-1, on that edge:
    - cout<=adder_cout.
    - ovf<=(a_reg[MSB]==b_reg[MSB]) & (adder_sum[W-1]!=a_reg[MSB]).
    - out_valid<=1; next state DONE.
  - in_valid is ignored in RUN; there is no abort input.
- DONE:
  - out_valid=1; result, cout and ovf are held stable.
  - adder_* outputs are driven to 0.
  - On out_valid & out_ready: out_valid<=0; next state IDLE.
  - The controller does not accept a new request in the same cycle the result is consumed. Minimum issue interval is CHUNKS+2 cycles.
- Latency: with acceptance at edge T, out_valid rises at edge T+CHUNKS.
- idx width is clog2(CHUNKS). idx wraps back to 0 only on entry to RUN.
- Reset asserted mid-RUN or in DONE: immediate return to the reset state. The partial result is discarded; out_valid drops with no handshake.
- Backpressure in DONE has no duration limit. Outputs must not glitch while held.
- Arithmetic:
  - All operands are unsigned bit-vectors.
  - Subtraction is A + ~B + 1, implemented as the inverted B plus the initial carry.
  - cout is the raw carry-out of the top chunk.

Test Plan:
- Carry chain across all chunks: A=0xFFFF_FFFF_FFFF_FFFF, B=1, sub=0 -> result=0, cout=1, ovf=0. out_valid rises 4 edges after acceptance. adder_cin is observed as 0,1,1,1 in RUN cycles 0..3.
- Subtract with borrow: A=5, B=7, sub=1 -> result=0xFFFF_FFFF_FFFF_FFFE, cout=0, ovf=0. adder_b in chunk 0 is 0xFFF8.
- Signed overflow: A=0x7FFF_FFFF_FFFF_FFFF, B=1, sub=0 -> result=0x8000_0000_0000_0000, cout=0, ovf=1. Also A=0x8000_0000_0000_0000, B=1, sub=1 -> result=0x7FFF_FFFF_FFFF_FFFF, ovf=1, cout=1.
- Backpressure: hold out_ready=0 for 5 cycles in DONE with in_valid=1 throughout.
  - Required: result stable; in_ready=0; no new request accepted.
  - After out_ready=1 for one cycle: IDLE, and the pending request is accepted on the next edge.
- Reset mid-operation: assert rst_n=0 when idx==2 with A=0x0000_FFFF_FFFF_FFFF, B=1.
  - Required: state IDLE, out_valid=0, result=0, in_ready=1 immediately (asynchronously).
  - Rerun the same request after reset releases -> result=0x0001_0000_0000_0000.
- Back-to-back: issue two requests with out_ready tied to 1 (3+4, then 10-3).
  - Required results 7 then 7.
  - Acceptance edges are exactly CHUNKS+2=6 cycles apart.
